// File: rtl/aes_pkg.sv
// aes_pkg: AES-256 decrypt constants, inverse S-box, GF(2^8) helpers, FSM states
package aes_pkg;
  localparam int NR = 14;
  localparam int BLOCK_W = 128;
  localparam int SCHED_W = BLOCK_W * (NR + 1);
  typedef enum logic [1:0] {LOAD, ROUND, FINAL} state_t;
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic logic [7:0] inv_sub(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] inv_mix(input logic [7:0] a, b, c, d);
    return gf_mul(a, 4'he) ^ gf_mul(b, 4'hb) ^ gf_mul(c, 4'hd) ^ gf_mul(d, 4'h9);
  endfunction
  function automatic logic [6:0] seg7(input logic [7:0] d);
    return d < 8'd10 ? SEG[d[3:0]] : 7'h7f;
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; is_final skips InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               is_final,
  output logic [BLOCK_W-1:0] result
);
  logic [7:0] ak [16];
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign ak[i] = inv_sub(state[BLOCK_W-1-8*((i%4)+4*(((i/4)+4-(i%4))%4)) -: 8])
                 ^ round_key[BLOCK_W-1-8*i -: 8];
  end
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign result[BLOCK_W-1-32*c -: 32] = is_final
      ? {ak[4*c], ak[4*c+1], ak[4*c+2], ak[4*c+3]}
      : {inv_mix(ak[4*c],   ak[4*c+1], ak[4*c+2], ak[4*c+3]),
         inv_mix(ak[4*c+1], ak[4*c+2], ak[4*c+3], ak[4*c]),
         inv_mix(ak[4*c+2], ak[4*c+3], ak[4*c],   ak[4*c+1]),
         inv_mix(ak[4*c+3], ak[4*c],   ak[4*c+1], ak[4*c+2])};
  end
endmodule

// File: rtl/aes_decrypt.sv
// aes_decrypt: free-running AES-256 decrypt, 15 cycles/block, decimal HEX readout when AES_DEC_HEX_EN
module aes_decrypt
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] in,
  input  logic [SCHED_W-1:0] expanded_key,
  input  logic [1:0]         switch,
  output logic [BLOCK_W-1:0] out,
  output logic               done,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3
);
  state_t fsm;
  logic [3:0] cnt;
  logic [BLOCK_W-1:0] st, rnd;
  logic [BLOCK_W-1:0] rk [NR+1];
  for (genvar i = 0; i <= NR; i++) begin : g_rk
    assign rk[i] = expanded_key[SCHED_W-1-BLOCK_W*i -: BLOCK_W];
  end
  aes_inv_round u_round (
    .state(st),
    .round_key(rk[cnt]),
    .is_final(fsm == FINAL),
    .result(rnd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fsm <= LOAD;
      cnt <= '0;
      st <= '0;
      out <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        LOAD: begin
          st <= in ^ rk[NR];
          cnt <= 4'(NR - 1);
          fsm <= ROUND;
        end
        ROUND: begin
          st <= rnd;
          cnt <= cnt - 4'd1;
          fsm <= cnt == 4'd1 ? FINAL : ROUND;
        end
        default: begin
          out <= rnd;
          done <= 1'b1;
          fsm <= LOAD;
        end
      endcase
    end
`ifdef AES_DEC_HEX_EN
  logic [7:0] b;
  assign b = out[BLOCK_W-1-8*switch -: 8];
  assign HEX3 = seg7(b / 8'd100);
  assign HEX2 = seg7((b / 8'd10) % 8'd10);
  assign HEX1 = seg7(b % 8'd10);
`else
  logic unused_switch;
  assign unused_switch = ^switch;
  assign {HEX3, HEX2, HEX1} = {3{7'h7f}};
`endif
endmodule

// File: tb/tb_aes_decrypt.sv
// tb_aes_decrypt: scoreboard bench for aes_decrypt with FIPS-197 and model-encrypted vectors
module tb_aes_decrypt;
  localparam logic [7:0] SB [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam logic [6:0] DIG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
`ifdef AES_DEC_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [127:0] PT_A = 128'hffc80a630123456789abcdeffedcba98;
  localparam logic [127:0] PT_B = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  logic clk = 1'b0;
  logic rst_n;
  logic [127:0] in;
  logic [1919:0] expanded_key;
  logic [1:0] switch;
  logic [127:0] out;
  logic done;
  logic [6:0] HEX1, HEX2, HEX3;
  int checks = 0;
  int errors = 0;
  int lat = 0;
  logic [127:0] expq [$];
  logic [1919:0] ek_c3, ek_z;
  logic [127:0] ct_a, ct_b;
  aes_decrypt dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .expanded_key(expanded_key),
    .switch(switch),
    .out(out),
    .done(done),
    .HEX1(HEX1),
    .HEX2(HEX2),
    .HEX3(HEX3)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [1919:0] expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] e;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = {SB[t[23:16]], SB[t[15:8]], SB[t[7:0]], SB[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]};
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) e[1919-32*i -: 32] = w[i];
    return e;
  endfunction
  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [1919:0] e);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] k, r;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ e[1919-8*i -: 8];
    for (int n = 1; n <= 14; n++) begin
      k = e[1919-128*n -: 128];
      for (int i = 0; i < 16; i++) t[i] = SB[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (n < 14) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic check_hex(input logic [1:0] s, input int h, input int t, input int u);
    switch = s;
    #1;
    chk($sformatf("hex3_sw%0d", s), 128'(HEX3), 128'(HEX_EN ? DIG[h] : 7'h7f));
    chk($sformatf("hex2_sw%0d", s), 128'(HEX2), 128'(HEX_EN ? DIG[t] : 7'h7f));
    chk($sformatf("hex1_sw%0d", s), 128'(HEX1), 128'(HEX_EN ? DIG[u] : 7'h7f));
  endtask
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout got no done within %0d cycles want done", tag, n);
    end
  endtask
  initial begin
    rst_n = 1'b1;
    switch = 2'd0;
    in = '0;
    expanded_key = '0;
    ek_c3 = expand(C3_KEY);
    ek_z = expand(256'h0);
    if (enc(C3_PT, ek_c3) !== C3_CT || enc(128'h0, ek_z) !== Z_CT) begin
      $display("FAIL model_selftest got %h want %h", enc(C3_PT, ek_c3), C3_CT);
      $fatal(1, "bench model broken");
    end
    ct_a = enc(PT_A, ek_c3);
    ct_b = enc(PT_B, ek_c3);
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) lat = 0;
        else begin
          lat++;
          if (done) begin
            chk("done_latency", 128'(lat), 128'd15);
            lat = 0;
            if (expq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done got out=%h want no done", out);
            end else chk("out", out, expq.pop_front());
          end
        end
      end
    join_none
    #1 rst_n = 1'b0;
    in = C3_CT;
    expanded_key = ek_c3;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    check_hex(2'd2, 0, 0, 0);
    switch = 2'd0;
    @(negedge clk);
    #1;
    expq.push_back(C3_PT);
    rst_n = 1'b1;
    wait_done("c3");
    in = Z_CT;
    expanded_key = ek_z;
    expq.push_back(128'h0);
    check_hex(2'd0, 0, 0, 0);
    check_hex(2'd1, 0, 1, 7);
    check_hex(2'd2, 0, 3, 4);
    check_hex(2'd3, 0, 5, 1);
    wait_done("zero_key");
    in = ct_a;
    expanded_key = ek_c3;
    expq.push_back(PT_A);
    repeat (5) @(posedge clk);
    #1;
    in = ct_b;
    expq.push_back(PT_B);
    wait_done("block_a");
    check_hex(2'd0, 2, 5, 5);
    check_hex(2'd1, 2, 0, 0);
    check_hex(2'd2, 0, 1, 0);
    check_hex(2'd3, 0, 9, 9);
    wait_done("block_b");
    in = C3_CT;
    expq.push_back(C3_PT);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    expq.delete();
    #1;
    chk("midrst_out", out, 128'h0);
    chk("midrst_done", 128'(done), 128'h0);
    repeat (2) @(negedge clk);
    check_hex(2'd2, 0, 0, 0);
    @(negedge clk);
    #1;
    expq.push_back(C3_PT);
    rst_n = 1'b1;
    wait_done("c3_after_reset");
    check_hex(2'd2, 0, 3, 4);
    @(negedge clk);
    #1;
    chk("queue_drained", 128'(expq.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_decrypt.md
# aes_decrypt

Iterative AES-256 inverse cipher (FIPS-197 InvCipher, Nk=8, Nr=14) that decrypts one 128-bit block per 15 clock cycles using a precomputed 15-round-key schedule supplied by the upstream key-expansion block. It sits between the key expander and the board I/O layer. It continuously re-samples its input block and drives a decimal 7-segment readout of one selectable plaintext byte.

## Interface
- No parameters; Nr=14 and the 15-key schedule are fixed constants.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in  in  128  ciphertext block; FIPS byte 0 = in[127:120], column-major state
- expanded_key  in  1920  round keys; round key r = expanded_key[1919-128r -: 128] (rk0 at MSBs, rk14 at LSBs)
- switch  in  2  display byte select
- out  out  128  registered plaintext, same byte order as in
- done  out  1  one-cycle pulse when out updates
- HEX1, HEX2, HEX3  out  7 each  active-low 7-segment {g,f,e,d,c,b,a}: units, tens, hundreds

## Operation
- FSM states: LOAD, ROUND, FINAL.
- LOAD: state <= in ^ rk14; round counter <= 13; go ROUND.
- ROUND (counter 13 down to 1): state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[counter])); decrement; after counter 1, go FINAL.
- FINAL: out <= InvSubBytes(InvShiftRows(state)) ^ rk0; done <= 1; go LOAD.
- Free-running: in and expanded_key are sampled at each LOAD; changes mid-block do not affect the block in flight except through the round keys read that cycle. Hold keys stable during a block.
- InvMixColumns: GF(2^8) matrix {0e,0b,0d,09}, reduction polynomial 0x11B.
- Display: selected byte b = out[127-8·switch -: 8] (switch 0 → byte 0 … 3 → byte 3). The value 0–255 is shown in decimal; hundreds on HEX3, tens on HEX2, units on HEX1, with leading zeros shown. Display logic is combinational from out and switch.
- Digit encoding (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Reset values: state FSM = LOAD, out = 0, done = 0, counter = 0. HEX1..HEX3 then show "000" (7'b1000000 each).
- Reset asserted mid-block: the block is aborted immediately and outputs return to reset values. The first LOAD occurs on the first rising edge after rst_n deasserts.
- Latency: 1 LOAD + 13 ROUND + 1 FINAL = 15 cycles from the sampling edge to the out update.
- done is high for exactly one cycle every 15 cycles, coincident with the new out value.
- switch change is reflected on HEX combinationally, with zero latency.

## Configuration
- AES_DEC_HEX_EN defined: 7-segment decode as above.
- AES_DEC_HEX_EN undefined: decode logic absent; HEX1..HEX3 tied to 7'h7F (all segments off). Cipher behaviour is unchanged.

## Structure
- Shared package aes_pkg: Nr=14, block/key width constants, the 256-entry inverse S-box constant, a gf_mul helper (xtime-based), and the FSM state enum.
- One sub-module, aes_inv_round: a combinational round with inputs state, round key and an is_final flag; it skips InvMixColumns when is_final is set. The top module holds the FSM, registers and display.

## Test plan
- FIPS-197 C.3: key 000102…1e1f, expanded externally; in = 8ea2b7ca516745bfeafc49904b496089 → out = 00112233445566778899aabbccddeeff with done pulsing 15 cycles after reset release.
- Same vector, switch=2 → HEX3/HEX2/HEX1 show "034" (0x22). switch=1 → "017". switch=3 → "051". switch=0 → "000".
- Reset: hold rst_n low → out=0, done=0, HEX all 7'b1000000. Assert rst_n at cycle 7 of a block → no done pulse for that block. The full 15-cycle latency restarts after release.
- Back-to-back blocks: change in to a second FIPS-verified ciphertext during ROUND → the first block still decrypts correctly. The new block result appears on the following done pulse, exactly 15 cycles later.
- Round-key ordering check: key schedule of all-zero key, in = dc95c078a2408989ad48a21492842087 → out = 00000000000000000000000000000000.
- AES_DEC_HEX_EN undefined → HEX1..HEX3 = 7'h7F for all switch values; out is unchanged.
